// File: rtl/smoketest_tally_pkg.sv
// Shared definitions for the smoke-test result collector.
//   tally_state_e : collector FSM states (IDLE, IN_TEST, DONE)
//   CNT_W_DEFAULT : default width of every tally counter
//   sat_max()     : all-ones value of a counter of the given width
package smoketest_tally_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_TEST = 2'd1,
    DONE    = 2'd2
  } tally_state_e;

  localparam int CNT_W_DEFAULT = 8;

  function automatic logic [31:0] sat_max(input int width);
    sat_max = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/smoketest_tally_sat_counter.sv
// Saturating up-counter used for every tally.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears q
//   inc : count one event this cycle
//   q   : current count, holds at 2^W-1 instead of wrapping
module sat_counter
  import smoketest_tally_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = W'(sat_max(W));

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/smoketest_tally.sv
// Smoke-test result collector. Consumes single-cycle event pulses from a
// smoke-test wrapper, keeps saturating tallies and produces a latched
// suite pass/fail verdict.
// Optional build macro: SMOKETEST_TIMEOUT_EN adds a per-test watchdog that
// force-closes a test as failed after TIMEOUT_CYCLES cycles in IN_TEST, and
// adds the timeouts output.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   test_start/end    : open / close a test
//   error_evt/info_evt: ERROR and INFO events from the running test
//   suite_end         : all tests finished, enter terminal DONE
//   tests_run, tests_failed, errors_total, infos_total : saturating tallies
//   cur_test_failed   : open test has logged an error
//   in_test, suite_done : FSM is in IN_TEST / DONE
//   protocol_err      : sticky illegal-sequence flag
//   suite_pass        : verdict, meaningful while suite_done=1
//   timeouts          : (watchdog build only) force-close count
module smoketest_tally
  import smoketest_tally_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             test_start,
  input  logic             test_end,
  input  logic             error_evt,
  input  logic             info_evt,
  input  logic             suite_end,
  output logic [CNT_W-1:0] tests_run,
  output logic [CNT_W-1:0] tests_failed,
  output logic [CNT_W-1:0] errors_total,
  output logic [CNT_W-1:0] infos_total,
  output logic             cur_test_failed,
  output logic             in_test,
  output logic             protocol_err,
  output logic             suite_done,
`ifdef SMOKETEST_TIMEOUT_EN
  output logic [CNT_W-1:0] timeouts,
`endif
  output logic             suite_pass
);

  if (CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("smoketest_tally: CNT_W and TIMEOUT_CYCLES must be >= 1");
  end

  tally_state_e state, state_next;
  logic cur_failed_next, proto_next, pass_next;
  logic inc_run, inc_fail, inc_err, inc_info;
  logic closing_bad;

  // An error arriving together with the closing event belongs to that test.
  assign closing_bad = cur_test_failed | error_evt;

`ifdef SMOKETEST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
  logic timeout_hit;
  logic restart;

  // A test_start while open reopens the test, so the watchdog restarts too.
  assign restart = (state == IN_TEST) && test_start && !suite_end;

  always_ff @(posedge clk) begin
    if (rst || state != IN_TEST || restart) begin
      wd <= '0;
    end else begin
      wd <= wd + WD_W'(1);
    end
  end
`endif

  always_comb begin
    state_next      = state;
    cur_failed_next = cur_test_failed;
    proto_next      = protocol_err;
    pass_next       = suite_pass;
    inc_run         = 1'b0;
    inc_fail        = 1'b0;
    inc_err         = 1'b0;
    inc_info        = 1'b0;
`ifdef SMOKETEST_TIMEOUT_EN
    timeout_hit     = 1'b0;
`endif
    case (state)
      IDLE: begin
        inc_err  = error_evt;
        inc_info = info_evt;
        if (error_evt || test_end) proto_next = 1'b1;
        // suite_end takes priority over a simultaneous test_start.
        if (suite_end) begin
          state_next = DONE;
        end else if (test_start) begin
          state_next      = IN_TEST;
          cur_failed_next = 1'b0;
        end
      end
      IN_TEST: begin
        inc_err  = error_evt;
        inc_info = info_evt;
        if (suite_end) begin
          // With test_end this is an orderly close; alone it aborts the test.
          inc_run         = 1'b1;
          inc_fail        = test_end ? closing_bad : 1'b1;
          if (!test_end) proto_next = 1'b1;
          cur_failed_next = 1'b0;
          state_next      = DONE;
        end else if (test_start) begin
          proto_next      = 1'b1;
          inc_run         = 1'b1;
          inc_fail        = 1'b1;
          cur_failed_next = 1'b0;
        end else if (test_end) begin
          inc_run         = 1'b1;
          inc_fail        = closing_bad;
          cur_failed_next = 1'b0;
          state_next      = IDLE;
`ifdef SMOKETEST_TIMEOUT_EN
        end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
          inc_run         = 1'b1;
          inc_fail        = 1'b1;
          timeout_hit     = 1'b1;
          cur_failed_next = 1'b0;
          state_next      = IDLE;
`endif
        end else if (error_evt) begin
          cur_failed_next = 1'b1;
        end
      end
      default: begin
      end
    endcase
    // Verdict uses the tallies as they will be after this cycle's update.
    if (state != DONE && state_next == DONE) begin
      pass_next = (tests_failed == '0) && !inc_fail &&
                  ((tests_run != '0) || inc_run) && !proto_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cur_test_failed <= 1'b0;
      protocol_err    <= 1'b0;
      suite_pass      <= 1'b0;
      in_test         <= 1'b0;
      suite_done      <= 1'b0;
    end else begin
      state           <= state_next;
      cur_test_failed <= cur_failed_next;
      protocol_err    <= proto_next;
      suite_pass      <= pass_next;
      in_test         <= (state_next == IN_TEST);
      suite_done      <= (state_next == DONE);
    end
  end

  sat_counter #(.W(CNT_W)) u_run  (.clk(clk), .rst(rst), .inc(inc_run),  .q(tests_run));
  sat_counter #(.W(CNT_W)) u_fail (.clk(clk), .rst(rst), .inc(inc_fail), .q(tests_failed));
  sat_counter #(.W(CNT_W)) u_err  (.clk(clk), .rst(rst), .inc(inc_err),  .q(errors_total));
  sat_counter #(.W(CNT_W)) u_info (.clk(clk), .rst(rst), .inc(inc_info), .q(infos_total));
`ifdef SMOKETEST_TIMEOUT_EN
  sat_counter #(.W(CNT_W)) u_tout (.clk(clk), .rst(rst), .inc(timeout_hit), .q(timeouts));
`endif

endmodule
